crc_frame_serializer: RTL

//  Downstream consumer of the serial CRC-9 generator, g(y)=y^9+y^8+y+1.

---
 rtl/crc_frame_serializer_pkg.sv | 29 ++
 rtl/crc_frame_serializer_lfsr.sv | 26 ++
 rtl/crc_frame_serializer.sv | 119 +++++++++++
 3 files changed

// File: rtl/crc_frame_serializer_pkg.sv
// Shared widths, polynomial, FSM encoding and the
// single-step CRC-9 update used by the serializer.
package crc_frame_serializer_pkg;

  localparam int MSG_W = 10;
  localparam int CRC_W = 9;
  localparam int CNT_W = 4;

  localparam logic [CRC_W-1:0] POLY = 9'h103;

  localparam logic [CNT_W-1:0] CNT_MSG = CNT_W'(MSG_W - 1);
  localparam logic [CNT_W-1:0] CNT_CRC = CNT_W'(CRC_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MSG  = 2'd1,
    ST_CRC  = 2'd2
  } state_t;

  function automatic logic [CRC_W-1:0] crc_step(
    input logic [CRC_W-1:0] s,
    input logic             din
  );
    logic fb;
    fb = din ^ s[CRC_W-1];
    return {s[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
  endfunction

endpackage

// File: rtl/crc_frame_serializer_lfsr.sv
// Serial CRC-9 division register: absorbs message bits,
// then shifts the remainder out MSB first.
module crc_lfsr_serial
  import crc_frame_serializer_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             step,
  input  logic             shift_out,
  input  logic             din,
  output logic [CRC_W-1:0] state
);

  // Division step while absorbing, plain shift while emitting.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      state <= '0;
    end else if (step) begin
      state <= crc_step(state, din);
    end else if (shift_out) begin
      state <= {state[CRC_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/crc_frame_serializer.sv
// Frame serializer: one parallel word in, message bits then
// CRC-9 remainder out serially with sof/eof/crc markers.
module crc_frame_serializer
  import crc_frame_serializer_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [MSG_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_bit,
  output logic             out_sof,
  output logic             out_eof,
  output logic             out_is_crc,
  output logic [CRC_W-1:0] crc_out,
  output logic             crc_done
);

  state_t             state_q;
  state_t             state_d;
  logic [MSG_W-1:0]   msg_sh;
  logic [CNT_W-1:0]   cnt;
  logic [CRC_W-1:0]   lfsr;
  logic               lfsr_clr;
  logic               lfsr_step;
  logic               lfsr_shift;
  logic               is_idle;
  logic               is_msg;
  logic               is_crc;
  logic               beat;

  assign is_idle = (state_q == ST_IDLE);
  assign is_msg  = (state_q == ST_MSG);
  assign is_crc  = (state_q == ST_CRC);
  assign beat    = out_valid & out_ready;

  assign in_ready   = is_idle;
  assign out_valid  = is_msg | is_crc;
  assign out_bit    = is_msg ? msg_sh[MSG_W-1]
                             : (is_crc & lfsr[CRC_W-1]);
  assign out_sof    = is_msg & (cnt == CNT_MSG);
  assign out_eof    = is_crc & (cnt == '0);
  assign out_is_crc = is_crc;

  crc_lfsr_serial u_lfsr (
    .clk       (clk),
    .reset     (reset),
    .clr       (lfsr_clr),
    .step      (lfsr_step),
    .shift_out (lfsr_shift),
    .din       (out_bit),
    .state     (lfsr)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state and LFSR control decode.
  always_comb begin
    state_d    = state_q;
    lfsr_clr   = 1'b0;
    lfsr_step  = 1'b0;
    lfsr_shift = 1'b0;
    unique case (1'b1)
      is_idle: begin
        if (in_valid) begin
          state_d  = ST_MSG;
          lfsr_clr = 1'b1;
        end
      end
      is_msg: begin
        if (beat) begin
          lfsr_step = 1'b1;
          if (cnt == '0) state_d = ST_CRC;
        end
      end
      is_crc: begin
        if (beat) begin
          lfsr_shift = 1'b1;
          if (cnt == '0) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Message shifter, beat counter and CRC status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      msg_sh   <= '0;
      cnt      <= '0;
      crc_out  <= '0;
      crc_done <= 1'b0;
    end else begin
      crc_done <= 1'b0;
      if (is_idle && in_valid) begin
        msg_sh <= in_data;
        cnt    <= CNT_MSG;
      end else if (is_msg && beat) begin
        msg_sh <= {msg_sh[MSG_W-2:0], 1'b0};
        if (cnt == '0) begin
          cnt     <= CNT_CRC;
          crc_out <= crc_step(lfsr, out_bit);
        end else begin
          cnt <= cnt - 1'b1;
        end
      end else if (is_crc && beat) begin
        if (cnt == '0) crc_done <= 1'b1;
        else           cnt      <= cnt - 1'b1;
      end
    end
  end

endmodule
